wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (src0) and a multi-cycle unit such as the divider or a load miss (src1).
- src1 results are captured into a one-entry pending buffer and drained onto the write port when src0 leaves the port idle.
- An age counter forces a drain, with a one-cycle pipeline stall, when src1 has waited too long.
- Sits between the MEM/WB stage and the regfile write port. It exports pending-entry status so decode can interlock on the pending register.

Parameters:
- MAX_WAIT, 4, number of cycles a pending entry may lose arbitration before a forced drain; legal range 1..7.
- CNT_W, 3, width of the age counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- src0_we  in  1  pipeline writeback enable.
- src0_waddr  in  `RegAddrBus  pipeline writeback register address.
- src0_wdata  in  `RegBus  pipeline writeback data.
- src1_valid  in  1  multi-cycle unit result valid.
- src1_ready  out  1  arbiter can accept a src1 result this cycle.
- src1_waddr  in  `RegAddrBus  multi-cycle result register address.
- src1_wdata  in  `RegBus  multi-cycle result data.
- we  out  1  regfile write enable.
- waddr  out  `RegAddrBus  regfile write address.
- wdata  out  `RegBus  regfile write data.
- stall_req  out  1  pipeline must hold WB this cycle; src0 write is not performed.
- pend_busy  out  1  pending entry valid.
- pend_addr  out  `RegAddrBus  pending entry address; 0 when pend_busy=0.

Behaviour:
- State: pend_valid, pend_addr, pend_data, wait_cnt.
- Reset (async): all state cleared. Outputs while rst=1: we=0, waddr=0, wdata=`ZeroWord, stall_req=0, src1_ready=0, pend_busy=0, pend_addr=0. Any in-flight pending entry is discarded.
- src0_live = src0_we & (src0_waddr != 0).
- force = pend_valid & (wait_cnt == MAX_WAIT).
- stall_req = force.
- drain = pend_valid & (force | ~src0_live).
- Write port, combinational, in priority order:
  - if drain: we=1, waddr=pend_addr, wdata=pend_data.
  - else if src0_live: we=1, port driven by src0.
  - else: we=0, waddr=0, wdata=0.
- A write to address 0 from either source never asserts we.
- Collision: pend_valid and src0_live with src0_waddr==pend_addr and no force means the newer pipeline write wins. The pending entry is dropped that edge without being written, and wait_cnt is cleared.
- src1_ready = ~rst & (~pend_valid | drain). Same-cycle drain and refill is allowed.
- Capture: on src1_valid & src1_ready at posedge, the pending buffer loads src1_waddr and src1_wdata, and wait_cnt=0.
  - A src1 result with waddr 0 is accepted and discarded; pend_valid stays 0.
- Age counter: when pend_valid & ~drain & no collision, wait_cnt increments, saturating at MAX_WAIT.
- Latency: src1 accept at edge N gives an earliest regfile write at edge N+1.
- Worst case: the write occurs at edge N+1+MAX_WAIT.
- Stall contract: while stall_req=1 the pipeline keeps src0 signals stable. They are written on the following cycle, when pend_valid=0 or a new entry has just been captured with wait_cnt=0.
- pend_busy mirrors pend_valid. Decode stalls any instruction that reads or writes pend_addr while pend_busy=1.

Decomposition:
- Shared defines package: `RegAddrBus, `RegBus, `ZeroWord, `RstEnable, `WriteEnable, `ReqNumLog2, plus WB_MAX_WAIT.
- One natural sub-module: wb_pend_buf. It holds the one-entry buffer, the age counter, and the collision-drop logic.
- The top level holds the port mux and the stall/ready logic.

Test Plan:
- Reset mid-operation: with a pending entry (addr 5) and src0 writing addr 3, assert rst asynchronously. Required: we, stall_req, pend_busy and src1_ready fall to 0 immediately; after release, no write to addr 5 ever occurs.
- Idle drain: src1 accepts (addr 7, 0xDEADBEEF) at edge N with src0_we=0. Required: we=1, waddr=7, wdata=0xDEADBEEF in the cycle after N; then pend_busy=0.
- Starvation: src0 writes addr 1..9 every cycle and src1 submits addr 10 with MAX_WAIT=4. Required:
  - pending loses arbitration for 4 cycles;
  - the 5th cycle has stall_req=1 and writes addr 10;
  - the held src0 write lands the next cycle.
- Collision: pending addr 12 = 0x1111 waits while src0 writes addr 12 = 0x2222. Required: we=1, waddr=12, wdata=0x2222; pend_busy=0 next cycle; 0x1111 is never written.
- Address zero: src0 writes addr 0, and separately src1 delivers addr 0. Required: we stays 0 for both; src1_ready=1 and pend_busy stays 0.
- Back-to-back src1: src1_valid held high for 3 results with src0 idle. Required: src1_ready=1 each cycle, one write per cycle in order, with no bubbles after the first.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file bus widths and constants for the writeback port arbiter.
package wb_port_arbiter_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_W        = 32;
  localparam int REQ_NUM_LOG2 = 1;
  localparam int WB_MAX_WAIT  = 4;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_t;

  localparam reg_t      ZERO_WORD = '0;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback sources, regfile write port and pending-entry status of the arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic      src0_we;
  reg_addr_t src0_waddr;
  reg_t      src0_wdata;
  logic      src1_valid;
  logic      src1_ready;
  reg_addr_t src1_waddr;
  reg_t      src1_wdata;
  logic      we;
  reg_addr_t waddr;
  reg_t      wdata;
  logic      stall_req;
  logic      pend_busy;
  reg_addr_t pend_addr;

  modport master (
    output src0_we, src0_waddr, src0_wdata, src1_valid, src1_waddr, src1_wdata,
    input  src1_ready, we, waddr, wdata, stall_req, pend_busy, pend_addr
  );

  modport slave (
    input  src0_we, src0_waddr, src0_wdata, src1_valid, src1_waddr, src1_wdata,
    output src1_ready, we, waddr, wdata, stall_req, pend_busy, pend_addr
  );
endinterface

// File: rtl/wb_pend_buf.sv
// One-entry buffer for multi-cycle results with an age counter that forces a drain
// and drops the entry when a younger pipeline write hits the same register.
module wb_pend_buf
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = WB_MAX_WAIT,
  parameter int CNT_W    = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      cap,
  input  reg_addr_t cap_addr,
  input  reg_t      cap_data,
  input  logic      src0_live,
  input  reg_addr_t src0_waddr,
  output logic      pend_valid,
  output reg_addr_t pend_addr,
  output reg_t      pend_data,
  output logic      force_drain,
  output logic      drain
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             collide;

  assign force_drain = pend_valid & (wait_cnt == MAX_CNT);
  assign drain       = pend_valid & (force_drain | ~src0_live);
  // A younger pipeline write to the same register makes the pending value stale.
  assign collide     = pend_valid & src0_live & ~force_drain & (src0_waddr == pend_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      pend_valid <= 1'b0;
      pend_addr  <= ZERO_ADDR;
      pend_data  <= ZERO_WORD;
      wait_cnt   <= '0;
    end else if (cap) begin
      // Results targeting r0 are accepted but never become pending.
      pend_valid <= (cap_addr != ZERO_ADDR);
      pend_addr  <= cap_addr;
      pend_data  <= cap_data;
      wait_cnt   <= '0;
    end else if (drain | collide) begin
      pend_valid <= 1'b0;
      wait_cnt   <= '0;
    end else if (pend_valid && (wait_cnt != MAX_CNT)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, multi-cycle results
// drain from a pending entry when the port is idle or when they have aged out.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = WB_MAX_WAIT,
  parameter int CNT_W    = 3
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);
  if ((MAX_WAIT < 1) || (MAX_WAIT > 7) || ((1 << CNT_W) <= MAX_WAIT)) begin : g_param_chk
    $error("wb_port_arbiter: MAX_WAIT/CNT_W out of range");
  end

  logic      src0_live;
  logic      cap;
  logic      pend_valid;
  logic      force_drain;
  logic      drain;
  reg_addr_t pend_addr_q;
  reg_t      pend_data;

  assign src0_live      = bus.src0_we & (bus.src0_waddr != ZERO_ADDR);
  assign bus.src1_ready = ~rst & (~pend_valid | drain);
  assign cap            = bus.src1_valid & bus.src1_ready;
  assign bus.stall_req  = ~rst & force_drain;
  assign bus.pend_busy  = pend_valid;
  assign bus.pend_addr  = pend_valid ? pend_addr_q : ZERO_ADDR;

  wb_pend_buf #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_pend_buf (
    .clk         (clk),
    .rst         (rst),
    .cap         (cap),
    .cap_addr    (bus.src1_waddr),
    .cap_data    (bus.src1_wdata),
    .src0_live   (src0_live),
    .src0_waddr  (bus.src0_waddr),
    .pend_valid  (pend_valid),
    .pend_addr   (pend_addr_q),
    .pend_data   (pend_data),
    .force_drain (force_drain),
    .drain       (drain)
  );

  always_comb begin
    bus.we    = 1'b0;
    bus.waddr = ZERO_ADDR;
    bus.wdata = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      bus.we = 1'b0;
    end else if (drain) begin
      bus.we    = WRITE_ENABLE;
      bus.waddr = pend_addr_q;
      bus.wdata = pend_data;
    end else if (src0_live) begin
      bus.we    = WRITE_ENABLE;
      bus.waddr = bus.src0_waddr;
      bus.wdata = bus.src0_wdata;
    end
  end
endmodule
